// File: rtl/sender_arbiter_if.sv
// Request/launch/completion signals between requesters, the arbiter and the sender.
// The arbiter takes the slave side; requesters and the sender drive the master side.
interface sender_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_i;
    logic [8*NUM_REQ-1:0]       req_data_i;
    logic [7:0]                 send_data;
    logic                       do_now;
    logic                       done_pulse;
    logic [NUM_REQ-1:0]         served_o;
    logic                       err_o;
    logic [$clog2(NUM_REQ)-1:0] err_idx_o;
    logic                       busy_o;

    modport master (
        output req_i, req_data_i, done_pulse,
        input  send_data, do_now, served_o, err_o, err_idx_o, busy_o
    );

    modport slave (
        input  req_i, req_data_i, done_pulse,
        output send_data, do_now, served_o, err_o, err_idx_o, busy_o
    );
endinterface

// File: rtl/sender_arbiter.sv
// Round-robin arbiter that hands one requester byte at a time to a single sender,
// waits for its completion pulse and aborts the transfer after TIMEOUT cycles.
module sender_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    sender_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  ptr, idx, grant, cand;
    logic           grant_vld;
    logic [7:0]     grant_byte;
    logic [7:0]     timer;
    logic           timer_hit;
    logic           success, abort;

    // Scan from the farthest candidate to the nearest so the one right after ptr wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (bus.req_i[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        grant_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == IW'(k)) grant_byte = bus.req_data_i[8*k +: 8];
        end
    end

    // Abort on the cycle whose increment would make the timer equal TIMEOUT.
    assign timer_hit = ({1'b0, timer} + 9'd1) == 9'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        success = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE:      if (grant_vld) state_n = LAUNCH;
            LAUNCH:    state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.done_pulse) begin
                    state_n = RELEASE;
                    success = 1'b1;
                end else if (timer_hit) begin
                    state_n = RELEASE;
                    abort   = 1'b1;
                end
            end
            RELEASE:   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Outputs are registered from the transition being taken, so each pulse
    // lands in the cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= IW'(NUM_REQ - 1);
            idx           <= '0;
            timer         <= '0;
            bus.send_data <= '0;
            bus.do_now    <= 1'b0;
            bus.served_o  <= '0;
            bus.err_o     <= 1'b0;
            bus.err_idx_o <= '0;
            bus.busy_o    <= 1'b0;
        end else begin
            bus.do_now   <= (state == IDLE) && grant_vld;
            bus.busy_o   <= (state_n != IDLE);
            bus.served_o <= success ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;
            bus.err_o    <= abort;
            if ((state == IDLE) && grant_vld) begin
                idx           <= grant;
                bus.send_data <= grant_byte;
            end
            if (state == LAUNCH)
                timer <= '0;
            else if ((state == WAIT_DONE) && !bus.done_pulse)
                timer <= timer + 8'd1;
            if (abort) bus.err_idx_o <= idx;
            if (state == RELEASE) ptr <= idx;
        end
    end
endmodule
